mux_n1_reg: RTL and testbench

- Parametrised N:1 registered multiplexer: the next-generation successor to the team's 2:1 gate-level mux cell.
- Adds configurable data width and channel count, a registered output with a valid/ready handshake, and an auto-scan (round-robin) mode with a programmable dwell.
- Sits between multi-source datapath registers and a single downstream consumer; also serves as the probe/log tap selector in simulation examples.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_scan_ctrl.sv | 68 ++++++
 rtl/mux_n1_reg.sv | 106 ++++++++++
 tb/tb_mux_n1_reg.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 multiplexer and its scan controller.
// Holds the select-width helper, the mode encodings and the reset values.
// Used by mux_scan_ctrl and mux_n1_reg.
package mux_pkg;

  // Mode encodings on the mode input.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Reset values for single-bit and fixed-width state.
  localparam logic       RST_VALID = 1'b0;
  localparam logic [7:0] RST_DWELL = 8'd0;

  // Select/pointer width: clog2 of the channel count, never below 1 bit.
  function automatic int selw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan pointer for the auto-scan mode of mux_n1_reg.
// Ports: clk, rst (sync, active-high), load (a word is loaded this edge),
//        mode, en_b, d_valid[NCH]; scan_ptr[SELW] is the channel to load next.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int DWELL = 1,
  localparam int SELW  = selw_f(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            mode,
  input  logic            en_b,
  input  logic [NCH-1:0]  d_valid,
  output logic [SELW-1:0] scan_ptr
);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            cur_vld;
  logic [SELW-1:0] ptr_adv;

  // Valid bit of the channel under the pointer; loop keeps the lookup in range
  // when NCH is not a power of two.
  always_comb begin
    cur_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if ({1'b0, ptr_q} == (SELW+1)'(k)) cur_vld = d_valid[k];
    end
  end

  assign ptr_adv = ({1'b0, ptr_q} == (SELW+1)'(NCH-1)) ? '0 : ptr_q + SELW'(1);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (mode != MODE_SCAN || en_b) begin
      // Outside active scanning the pointer parks at channel 0, so every
      // scan entry starts from the first channel.
      ptr_d = '0;
      cnt_d = RST_DWELL;
    end else if (load) begin
      // An empty channel is skipped at once so no channel can stall the scan;
      // a valid channel is held for DWELL loads.
      if (!cur_vld || cnt_q == 8'(DWELL-1)) begin
        ptr_d = ptr_adv;
        cnt_d = RST_DWELL;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= RST_DWELL;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign scan_ptr = ptr_q;

endmodule

// File: rtl/mux_n1_reg.sv
// Registered N:1 multiplexer with valid/ready output and round-robin auto-scan.
// Ports: clk, rst (sync, active-high), en_b (1 = zero/invalid), mode (0 manual,
//        1 scan), sel, d[NCH*WIDTH], d_valid[NCH]; y, y_ch, y_valid out, y_ready in.
module mux_n1_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  parameter  int DWELL = 1,
  localparam int SELW  = selw_f(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_b,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] d,
  input  logic [NCH-1:0]       d_valid,
  output logic [WIDTH-1:0]     y,
  output logic [SELW-1:0]      y_ch,
  output logic                 y_valid,
  input  logic                 y_ready
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             vld_q, vld_d;

  logic             load;
  logic [SELW-1:0]  scan_ptr;
  logic [SELW-1:0]  ch;
  logic             in_range;
  logic [WIDTH-1:0] pick_dat;
  logic             pick_vld;

  // The output register may take a new word whenever it is empty or its
  // current word is being accepted this cycle.
  assign load = !vld_q || y_ready;

  mux_scan_ctrl #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .mode     (mode),
    .en_b     (en_b),
    .d_valid  (d_valid),
    .scan_ptr (scan_ptr)
  );

  assign ch       = (mode == MODE_SCAN) ? scan_ptr : sel;
  // One extra bit so a manual select beyond the last channel is caught.
  assign in_range = ({1'b0, ch} < (SELW+1)'(NCH));

  always_comb begin
    pick_dat = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if ({1'b0, ch} == (SELW+1)'(k)) begin
        pick_dat = d[k*WIDTH +: WIDTH];
        pick_vld = d_valid[k];
      end
    end
  end

  always_comb begin
    y_d   = y_q;
    ch_d  = ch_q;
    vld_d = vld_q;
    if (load) begin
      if (en_b) begin
        y_d   = '0;
        ch_d  = '0;
        vld_d = 1'b0;
      end else if (in_range) begin
        y_d   = pick_dat;
        ch_d  = ch;
        vld_d = pick_vld;
      end else begin
        // Out-of-range select still reports which index was asked for.
        y_d   = '0;
        ch_d  = ch;
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      ch_q  <= '0;
      vld_q <= RST_VALID;
    end else begin
      y_q   <= y_d;
      ch_q  <= ch_d;
      vld_q <= vld_d;
    end
  end

  assign y       = y_q;
  assign y_ch    = ch_q;
  assign y_valid = vld_q;

endmodule

// File: tb/tb_mux_n1_reg.sv
// Bench for mux_n1_reg: a 4-channel DWELL=2 instance and a 3-channel DWELL=1 instance.
// Expected values come from constants, a word-level model and scan-order lists.
module tb_mux_n1_reg;

  localparam int W      = 8;
  localparam int N4     = 4;
  localparam int DW4    = 2;
  localparam int N3     = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NCH=4, DWELL=2
  logic        rst = 1'b1, en_b = 1'b0, mode = 1'b0, y_ready = 1'b1;
  logic [1:0]  sel = '0;
  logic [31:0] d = '0;
  logic [3:0]  d_valid = '0;
  logic [7:0]  y;
  logic [1:0]  y_ch;
  logic        y_valid;

  // Instance B: NCH=3, DWELL=1
  logic        rst3 = 1'b1, en_b3 = 1'b0, mode3 = 1'b0, y_ready3 = 1'b1;
  logic [1:0]  sel3 = '0;
  logic [23:0] d3 = '0;
  logic [2:0]  d_valid3 = '0;
  logic [7:0]  y3;
  logic [1:0]  y_ch3;
  logic        y_valid3;

  mux_n1_reg #(.WIDTH(W), .NCH(N4), .DWELL(DW4)) u_dut4 (
    .clk(clk), .rst(rst), .en_b(en_b), .mode(mode), .sel(sel), .d(d),
    .d_valid(d_valid), .y(y), .y_ch(y_ch), .y_valid(y_valid), .y_ready(y_ready)
  );

  mux_n1_reg #(.WIDTH(W), .NCH(N3), .DWELL(1)) u_dut3 (
    .clk(clk), .rst(rst3), .en_b(en_b3), .mode(mode3), .sel(sel3), .d(d3),
    .d_valid(d_valid3), .y(y3), .y_ch(y_ch3), .y_valid(y_valid3), .y_ready(y_ready3)
  );

  int errors = 0;
  int checks = 0;

  // Word-level model of instance A in manual mode.
  logic [7:0] m_y;
  logic [1:0] m_ch;
  logic       m_vld;

  function automatic logic [7:0] byte_of(input logic [31:0] v, input int k);
    return v[k*8 +: 8];
  endfunction

  // Predict what instance A holds after the coming edge (manual mode only).
  task automatic model_edge4();
    int c;
    if (rst) begin
      m_y = 0; m_ch = 0; m_vld = 0;
    end else if (!m_vld || y_ready) begin
      c = int'(sel);
      if (en_b) begin
        m_y = 0; m_ch = 0; m_vld = 0;
      end else if (c < N4) begin
        m_y = byte_of(d, c); m_ch = sel; m_vld = d_valid[c];
      end else begin
        m_y = 0; m_ch = sel; m_vld = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    model_edge4();
    tick();
    tick();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", y); end
    checks++; if (y_ch !== 2'd0) begin errors++; $display("FAIL reset_ych got=%0d exp=0", y_ch); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", y_valid); end
    checks++; if (y_valid3 !== 1'b0) begin errors++; $display("FAIL reset_vld3 got=%b exp=0", y_valid3); end
  endtask

  task automatic test_manual();
    rst = 1'b0; mode = 1'b0; en_b = 1'b0; y_ready = 1'b1;
    sel = 2'd2; d = 32'h0; d[23:16] = 8'hA5; d_valid = 4'b0100;
    model_edge4();
    tick();
    checks++; if (y !== 8'hA5) begin errors++; $display("FAIL manual_y got=%h exp=a5", y); end
    checks++; if (y_ch !== 2'd2) begin errors++; $display("FAIL manual_ych got=%0d exp=2", y_ch); end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL manual_vld got=%b exp=1", y_valid); end
    y_ready = 1'b0;
    rst = 1'b1;
    model_edge4();
    tick();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL midrst_y got=%h exp=00", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL midrst_vld got=%b exp=0", y_valid); end
    rst = 1'b0; y_ready = 1'b1;
  endtask

  task automatic test_backpressure();
    d[23:16] = 8'h11; d_valid = 4'b0100; sel = 2'd2;
    model_edge4();
    tick();
    checks++; if (y !== 8'h11 || y_valid !== 1'b1) begin
      errors++; $display("FAIL bp_load got=%h/%b exp=11/1", y, y_valid); end
    y_ready = 1'b0;
    d[23:16] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      // Disturb sel and en_b while stalled; the held word must not change.
      if (i == 1) sel = 2'd0;
      if (i == 2) en_b = 1'b1;
      model_edge4();
      tick();
      checks++; if (y !== 8'h11 || y_valid !== 1'b1 || y_ch !== 2'd2) begin
        errors++; $display("FAIL bp_hold%0d got=%h/%0d/%b exp=11/2/1", i, y, y_ch, y_valid); end
    end
    sel = 2'd2; en_b = 1'b0; y_ready = 1'b1;
    model_edge4();
    tick();
    checks++; if (y !== 8'h22) begin errors++; $display("FAIL bp_release got=%h exp=22", y); end
  endtask

  task automatic test_enable();
    en_b = 1'b1; y_ready = 1'b1;
    model_edge4();
    tick();
    checks++; if (y !== 8'h00 || y_valid !== 1'b0 || y_ch !== 2'd0) begin
      errors++; $display("FAIL en_zero got=%h/%0d/%b exp=00/0/0", y, y_ch, y_valid); end
    en_b = 1'b0; sel = 2'd1; d[15:8] = 8'h33; d_valid = 4'b0010;
    model_edge4();
    tick();
    y_ready = 1'b0; en_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_edge4();
      tick();
      checks++; if (y !== 8'h33 || y_valid !== 1'b1) begin
        errors++; $display("FAIL en_hold%0d got=%h/%b exp=33/1", i, y, y_valid); end
    end
    y_ready = 1'b1;
    model_edge4();
    tick();
    checks++; if (y !== 8'h00 || y_valid !== 1'b0) begin
      errors++; $display("FAIL en_drop got=%h/%b exp=00/0", y, y_valid); end
    en_b = 1'b0;
  endtask

  // Expected per-load scan order: each valid channel DWELL times, an invalid one once.
  int q_ch[$];
  bit q_v[$];
  task automatic gen_scan(input logic [3:0] v, input int n);
    int c;
    c = 0;
    q_ch.delete(); q_v.delete();
    while (q_ch.size() < n) begin
      if (v[c]) begin
        for (int r = 0; r < DW4; r++) begin q_ch.push_back(c); q_v.push_back(1'b1); end
      end else begin
        q_ch.push_back(c); q_v.push_back(1'b0);
      end
      c = (c + 1) % N4;
    end
  endtask

  task automatic test_scan();
    logic [7:0] e_y;
    int         e_ch, idx;
    bit         e_v;
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b1; en_b = 1'b0; y_ready = 1'b1; d_valid = 4'b1111;
    gen_scan(4'b1111, 9);
    for (int i = 0; i < 9; i++) begin
      d = $urandom;
      e_y = byte_of(d, q_ch[i]);
      tick();
      checks++; if (y_ch !== 2'(q_ch[i]) || y_valid !== 1'b1 || y !== e_y) begin
        errors++; $display("FAIL scan_all%0d got=%0d/%b/%h exp=%0d/1/%h", i, y_ch, y_valid, y, q_ch[i], e_y); end
    end
    // One manual load, then re-enter scan: it must start again at channel 0.
    mode = 1'b0; sel = 2'd1; d = $urandom;
    e_y = byte_of(d, 1);
    tick();
    checks++; if (y_ch !== 2'd1 || y !== e_y) begin
      errors++; $display("FAIL scan_manual got=%0d/%h exp=1/%h", y_ch, y, e_y); end
    mode = 1'b1; d_valid = 4'b1011;
    gen_scan(4'b1011, 40);
    e_v = 1'b1; e_ch = 1; idx = 0;
    for (int i = 0; i < 30; i++) begin
      d = $urandom;
      y_ready = ($urandom_range(0, 3) != 0);
      if (!e_v || y_ready) begin
        e_ch = q_ch[idx]; e_v = q_v[idx]; e_y = byte_of(d, e_ch); idx++;
      end
      tick();
      checks++; if (y_ch !== 2'(e_ch) || y_valid !== e_v || y !== e_y) begin
        errors++; $display("FAIL scan_skip%0d got=%0d/%b/%h exp=%0d/%b/%h", i, y_ch, y_valid, y, e_ch, e_v, e_y); end
    end
    mode = 1'b0; y_ready = 1'b1;
    rst = 1'b1; model_edge4(); tick(); rst = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [7:0] e_y;
    int exp_ch [4] = '{0, 1, 2, 0};
    rst3 = 1'b0; mode3 = 1'b0; en_b3 = 1'b0; y_ready3 = 1'b1;
    sel3 = 2'd3; d3 = 24'hFFFFFF; d_valid3 = 3'b111;
    tick();
    checks++; if (y3 !== 8'h00 || y_valid3 !== 1'b0 || y_ch3 !== 2'd3) begin
      errors++; $display("FAIL oor got=%h/%b/%0d exp=00/0/3", y3, y_valid3, y_ch3); end
    sel3 = 2'd1; d3 = $urandom;
    e_y = d3[15:8];
    tick();
    checks++; if (y3 !== e_y || y_valid3 !== 1'b1 || y_ch3 !== 2'd1) begin
      errors++; $display("FAIL oor_back got=%h/%b/%0d exp=%h/1/1", y3, y_valid3, y_ch3, e_y); end
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (y_ch3 !== 2'(exp_ch[i]) || y_valid3 !== 1'b1) begin
        errors++; $display("FAIL scan3_%0d got=%0d/%b exp=%0d/1", i, y_ch3, y_valid3, exp_ch[i]); end
    end
    mode3 = 1'b0; sel3 = 2'd2;
    tick();
    mode3 = 1'b1;
    tick();
    checks++; if (y_ch3 !== 2'd0) begin errors++; $display("FAIL scan3_restart got=%0d exp=0", y_ch3); end
  endtask

  task automatic test_throughput();
    logic [7:0] e_y;
    logic [1:0] e_ch;
    int nvalid;
    nvalid = 0;
    mode = 1'b0; en_b = 1'b0; y_ready = 1'b1; d_valid = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      sel = 2'($urandom_range(0, 3));
      d = $urandom;
      e_y = byte_of(d, int'(sel)); e_ch = sel;
      model_edge4();
      tick();
      if (y_valid === 1'b1) nvalid++;
      checks++; if (y !== e_y || y_ch !== e_ch || y_valid !== 1'b1) begin
        errors++; $display("FAIL thru%0d got=%h/%0d/%b exp=%h/%0d/1", i, y, y_ch, y_valid, e_y, e_ch); end
    end
    checks++; if (nvalid != 100) begin errors++; $display("FAIL thru_count got=%0d exp=100", nvalid); end
  endtask

  task automatic test_random_manual();
    for (int i = 0; i < 200; i++) begin
      sel = 2'($urandom_range(0, 3));
      d = $urandom;
      d_valid = 4'($urandom);
      en_b = ($urandom_range(0, 5) == 0);
      y_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 40) == 0);
      model_edge4();
      tick();
      checks++; if (y !== m_y || y_ch !== m_ch || y_valid !== m_vld) begin
        errors++; $display("FAIL rand%0d got=%h/%0d/%b exp=%h/%0d/%b", i, y, y_ch, y_valid, m_y, m_ch, m_vld); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_backpressure();
    test_enable();
    test_scan();
    test_out_of_range();
    test_throughput();
    test_random_manual();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
